// File: rtl/resonator_osc_mc.sv
// -----------------------------------------------------------------------------
// resonator_osc_mc
// Time-multiplexed multi-channel recursive sinusoid generator. Every channel
// runs y[n] = C*y[n-1] - y[n-2] (C = 2cos(w), Q(DW-FRAC).FRAC) through one
// shared multiplier, one channel per clock during a sweep. Frequency/phase
// reloads written through cfg_* are held in shadow registers and applied to a
// channel only when its y[n-1] sits inside the zero-crossing window, so a
// retune never produces a step in the output.
//
// Optional build macro: SAT_EN -- clamp the new sample to the DW-bit signed
// range instead of wrapping modulo 2^DW (default: wrap).
//
// Ports
//   Fg_CLK, RESETn       clock, asynchronous active-low reset
//   Ready                reload every channel from shadow now, abort sweep
//   Enable               start one sweep (ignored while busy)
//   zc_sel               0: window = top ZC_BITS bits, 1: top ZC_BITS-1 bits
//   cfg_wr/cfg_ch        write shadow regs of cfg_ch, mark it pending
//   cfg_init1/cfg_init2  reload magnitude sin(w) / reload coefficient C
//   busy                 sweep in progress
//   out_valid/out_ch     registered per-channel result strobe and channel
//   out_data             new y[n] of out_ch
//   sweep_done           strobe alongside the last channel's result
//   pending              per-channel reload-waiting flags
// -----------------------------------------------------------------------------
module resonator_osc_mc #(
   parameter int DW      = 32,
   parameter int FRAC    = 29,
   parameter int NCH     = 4,
   parameter int CH_W    = 2,
   parameter int ZC_BITS = 10
) (
   input  logic            Fg_CLK,
   input  logic            RESETn,
   input  logic            Ready,
   input  logic            Enable,
   input  logic            zc_sel,
   input  logic            cfg_wr,
   input  logic [CH_W-1:0] cfg_ch,
   input  logic [DW-1:0]   cfg_init1,
   input  logic [DW-1:0]   cfg_init2,
   output logic            busy,
   output logic            out_valid,
   output logic [CH_W-1:0] out_ch,
   output logic [DW-1:0]   out_data,
   output logic            sweep_done,
   output logic [NCH-1:0]  pending
);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t          state;
   logic [CH_W-1:0] k;

   logic signed [DW-1:0] y1      [NCH];
   logic signed [DW-1:0] y2      [NCH];
   logic signed [DW-1:0] coef    [NCH];
   logic signed [DW-1:0] sh_init [NCH];
   logic signed [DW-1:0] sh_coef [NCH];

   // Shared datapath: operands of the channel currently being processed
   logic signed [DW-1:0]   cy1, cy2, ccoef, cinit;
   logic signed [2*DW-1:0] prod, quo;
   logic signed [2*DW:0]   diff;
   logic signed [DW-1:0]   ystep, reload_val, ynew;
   logic                   zc, reload;
   logic                   lsb_unused;

   assign cy1   = y1[k];
   assign cy2   = y2[k];
   assign ccoef = coef[k];
   assign cinit = sh_init[k];

   // Operands sign-extended to 2*DW: the low 2*DW bits of the product are
   // the exact signed product.
   assign prod = {{DW{cy1[DW-1]}}, cy1} * {{DW{ccoef[DW-1]}}, ccoef};
   assign quo  = prod >>> FRAC;
   // One guard bit so q - y2 can never overflow before reduction
   assign diff = {quo[2*DW-1], quo} - {{(DW+1){cy2[DW-1]}}, cy2};
   assign lsb_unused = ^prod[FRAC-1:0];

`ifdef SAT_EN
   localparam logic signed [2*DW:0] SMAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [2*DW:0] SMIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
   always_comb begin
      ystep = diff[DW-1:0];
      if (diff > SMAX)      ystep = SMAX[DW-1:0];
      else if (diff < SMIN) ystep = SMIN[DW-1:0];
   end
`else
   logic wrap_unused;
   assign wrap_unused = ^diff[2*DW:DW];
   assign ystep = diff[DW-1:0];
`endif

   // Zero-crossing window: the top W bits of y1 are pure sign extension
   always_comb begin
      zc = (&cy1[DW-1 -: ZC_BITS]) | ~(|cy1[DW-1 -: ZC_BITS]);
      if (zc_sel)
         zc = (&cy1[DW-1 -: ZC_BITS-1]) | ~(|cy1[DW-1 -: ZC_BITS-1]);
   end

   assign reload = pending[k] & zc;
   // Restart with the sign that continues the half-wave y2 was heading into
   assign reload_val = cy2[DW-1] ? cinit : -cinit;
   assign ynew = reload ? reload_val : ystep;

   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         state      <= IDLE;
         k          <= '0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_data   <= '0;
         sweep_done <= 1'b0;
         pending    <= '0;
         for (int i = 0; i < NCH; i++) begin
            y1[i]      <= '0;
            y2[i]      <= '0;
            coef[i]    <= '0;
            sh_init[i] <= '0;
            sh_coef[i] <= '0;
         end
      end else begin
         out_valid  <= 1'b0;
         sweep_done <= 1'b0;
         if (Ready) begin
            for (int i = 0; i < NCH; i++) begin
               y1[i]   <= sh_init[i];
               y2[i]   <= '0;
               coef[i] <= sh_coef[i];
            end
            pending <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            k       <= '0;
         end else begin
            case (state)
               IDLE: if (Enable) begin
                  state <= SWEEP;
                  busy  <= 1'b1;
                  k     <= '0;
               end
               SWEEP: begin
                  if (reload) begin
                     y1[k]      <= reload_val;
                     y2[k]      <= '0;
                     coef[k]    <= sh_coef[k];
                     pending[k] <= 1'b0;
                  end else begin
                     y1[k] <= ystep;
                     y2[k] <= cy1;
                  end
                  out_valid <= 1'b1;
                  out_ch    <= k;
                  out_data  <= ynew;
                  if (k == CH_W'(NCH-1)) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     sweep_done <= 1'b1;
                     k          <= '0;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
         // Placed last so a new request survives a same-cycle clear
         if (cfg_wr) begin
            sh_init[cfg_ch] <= cfg_init1;
            sh_coef[cfg_ch] <= cfg_init2;
            pending[cfg_ch] <= 1'b1;
         end
      end
   end

endmodule

// File: doc/resonator_osc_mc.md
Name: resonator_osc_mc

Overview:
Time-multiplexed, parametrised multi-channel recursive sinusoid generator for the DDS function generator. Each channel iterates y[n] = C·y[n-1] − y[n-2] (C = 2cos ω, fixed point) through one shared multiplier. Per-channel frequency/phase reloads are queued and applied only at that channel's zero crossing, giving glitch-free retuning. Sits between the config/register block and the per-channel amplitude/DAC path.

Parameters:
DW, 32, sample and coefficient width (signed two's complement)
FRAC, 29, fractional bits of C (Q(DW-FRAC).FRAC)
NCH, 4, number of channels (≥2)
CH_W, 2, channel index width, = clog2(NCH)
ZC_BITS, 10, MSBs tested for zero-crossing window (≥2)

Ports:
Fg_CLK  in  1  clock
RESETn  in  1  async active-low reset
Ready  in  1  immediate reload of all channels from shadow registers
Enable  in  1  start one sweep (one new sample per channel)
zc_sel  in  1  0: window = top ZC_BITS bits; 1: top ZC_BITS-1 bits
cfg_wr  in  1  write shadow registers of channel cfg_ch, request reload
cfg_ch  in  CH_W  target channel
cfg_init1  in  DW  reload sample magnitude, sin(ω)
cfg_init2  in  DW  reload coefficient C
busy  out  1  sweep in progress
out_valid  out  1  one-cycle strobe per channel result
out_ch  out  CH_W  channel of out_data
out_data  out  DW  new y[n] of out_ch
sweep_done  out  1  one-cycle strobe with last channel result
pending  out  NCH  per-channel reload-waiting flags

Behaviour:
- Per-channel state: y1, y2, coef, shadow init, shadow coef. Reset: all zero; all outputs 0; FSM IDLE.
- FSM IDLE/SWEEP. IDLE & Enable -> SWEEP, channel counter k=0. SWEEP: one channel per cycle, k=0..NCH-1; after k=NCH-1 -> IDLE. Enable ignored while busy. busy=1 in SWEEP.
- Results registered: channel k result appears (out_valid=1, out_ch=k) cycle after it is processed; first result 2 cycles after Enable sampled. sweep_done coincides with out_ch=NCH-1. Enable in the cycle after return to IDLE is accepted (back-to-back sweeps, NCH+1 cycle period).
- Normal step for k: p = coef·y1 (2·DW signed), q = p >>> FRAC (arithmetic), s = q − y2 at full width; y_new = s reduced to DW (see SAT_EN). y2<=y1, y1<=y_new, out_data=y_new.
- Zero-cross: zc = top W bits of y1 all 0 or all 1 (W = ZC_BITS or ZC_BITS-1 per zc_sel).
- If pending[k] & zc at processing: reload instead of step: y1 <= (y2 sign bit =1) ? +init : −init (two's complement); y2<=0; coef<=shadow coef; pending[k]<=0; out_data = reloaded y1.
- cfg_wr: shadow[cfg_ch]<=inputs, pending[cfg_ch]<=1. Same cycle as a reload of that channel: shadow takes new values, pending stays 1 (reload consumed old shadow).
- Ready (highest priority): all channels y1<=+shadow init, y2<=0, coef<=shadow coef; pending all 0; abort sweep -> IDLE; no out_valid that cycle. cfg_wr same cycle as Ready: shadow written, pending set after clear.
- Async reset mid-sweep: immediate return to reset state.

Optional Feature:
SAT_EN: defined -> s clamped to [−2^(DW-1), 2^(DW-1)−1]. Undefined -> low DW bits of s (modulo wrap, legacy behaviour).

Test Plan:
- Reset, then shadow ch0 init=1000, C=0; Ready; 4 sweeps -> ch0 out_data 0, −1000, 0, 1000 (period 4).
- ch1 C=2^29 (2cos=1), init=1000, Ready; 6 sweeps -> 1000, 0, −1000, −1000, 0, 1000; out_ch sequence 0..3 each sweep, sweep_done on ch3.
- ch0 running with |y1| ≥ 2^22 (zc_sel=0); cfg_wr ch0 init=500 -> pending[0]=1 held until first sweep with |y1|<2^22, then out_data=±500 (sign from y2), y2=0, pending[0]=0.
- Same as above with zc_sel=1 -> reload when |y1|<2^23; verify earlier reload point.
- y1=2^30, y2=0, C=2^30 -> out_data 0x7FFFFFFF with SAT_EN, 0x80000000 without.
- Ready asserted mid-sweep (k=2), plus cfg_wr ch3 same cycle -> busy drops next cycle, no out_valid, all y reloaded, pending=4'b1000; Enable during busy ignored.
